// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb
//
// Integer register file with a per-register pending-write scoreboard.
// XLEN bits wide and NREG entries deep. It has two combinational read
// ports, one write port and one debug read port.
//
// Register 0 always reads as zero. Writes to register 0 are discarded, and
// it can never be marked busy. Register SP_IDX resets to SP_INIT, which is
// the top of the stack. Every other register resets to zero.
//
// The decode stage uses the scoreboard for RAW hazard detection:
//   - issue_en/issue_addr marks a register as having a write in flight.
//   - A writeback to a register clears its busy bit.
//   - If an issue and a writeback hit the same register in one cycle, the
//     busy bit stays set. The newly issued write is still outstanding.
// pend_cnt is a registered count of the busy bits. It is updated
// incrementally each cycle.
//
// The block never stalls and there is no handshake. Every input is acted on
// at the rising edge at which it is sampled. Stall decisions belong to the
// control unit.
//
// Optional feature (macro REGFILE_BYPASS_EN):
//   When this macro is defined, a same-cycle writeback is forwarded to rs1/rs2
//   (data, and a cleared busy bit unless a same-cycle issue re-marks that
//   register). The debug port is never forwarded. When the macro is not
//   defined, the read ports show stored state only.
//
// Parameters:
//   XLEN    data width of each register
//   NREG    number of registers (power of two, >= 2)
//   AW      address width, derived from NREG (do not override)
//   SP_IDX  index of the stack-pointer register (must be nonzero)
//   SP_INIT reset value of register SP_IDX
//
// Ports:
//   clk                 clock; all state changes on the rising edge
//   reset               synchronous, active-high reset
//   rs1_addr/rs2_addr   read addresses
//   rs1_data/rs2_data   read data (combinational)
//   rs1_busy/rs2_busy   scoreboard bit of the read address (combinational)
//   wr_en/wr_addr/wr_data   writeback port
//   issue_en/issue_addr     mark a register busy
//   pend_cnt            number of busy registers (registered)
//   dbg_addr/dbg_data   debug read port (combinational, never forwarded)
// -----------------------------------------------------------------------------
module regfile_sb #(
    parameter int          XLEN    = 32,
    parameter int          NREG    = 32,
    parameter int          AW      = $clog2(NREG),
    parameter int          SP_IDX  = 2,
    parameter int unsigned SP_INIT = 31
) (
    input  logic            clk,
    input  logic            reset,

    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,

    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,

    input  logic            issue_en,
    input  logic [AW-1:0]   issue_addr,
    output logic [AW:0]     pend_cnt,

    input  logic [AW-1:0]   dbg_addr,
    output logic [XLEN-1:0] dbg_data
);

    // -------------------------------------------------------------------------
    // Storage and scoreboard state
    // -------------------------------------------------------------------------
    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [AW:0]     cnt_q;
    logic [AW:0]     cnt_d;

    // Qualified write and issue strobes. Register 0 is excluded here once, so
    // nothing downstream has to treat address 0 specially.
    logic wr_hit;
    logic issue_hit;

    assign wr_hit    = wr_en    && (wr_addr    != '0);
    assign issue_hit = issue_en && (issue_addr != '0);

    // -------------------------------------------------------------------------
    // Register array
    // -------------------------------------------------------------------------
    // Entry 0 is cleared by reset and is never written. The read muxes below
    // also force address 0 to zero, so register 0 reads as zero even before
    // the first reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= (i == SP_IDX) ? XLEN'(SP_INIT) : '0;
            end
        end else if (wr_hit) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // -------------------------------------------------------------------------
    // Scoreboard next state
    // -------------------------------------------------------------------------
    // The clear is applied before the set. When an issue and a writeback hit
    // the same register, the bit therefore ends up set.
    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] clr_mask;
    logic            cnt_inc;
    logic            cnt_dec;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (issue_hit) begin
            set_mask[issue_addr] = 1'b1;
        end
        if (wr_hit) begin
            clr_mask[wr_addr] = 1'b1;
        end
        busy_d = (busy_q & ~clr_mask) | set_mask;
    end

    // Incremental popcount maintenance:
    //   +1 when a currently idle register becomes busy;
    //   -1 when a busy register is cleared and not re-marked in the same cycle.
    // A set and a clear on the same busy register leave the count unchanged.
    always_comb begin
        cnt_inc = issue_hit && !busy_q[issue_addr];
        cnt_dec = wr_hit && busy_q[wr_addr]
                  && !(issue_hit && (issue_addr == wr_addr));
        cnt_d   = cnt_q;
        case ({cnt_inc, cnt_dec})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pend_cnt = cnt_q;

    // -------------------------------------------------------------------------
    // Stored-state read values
    // -------------------------------------------------------------------------
    logic [XLEN-1:0] rs1_stored;
    logic [XLEN-1:0] rs2_stored;

    assign rs1_stored = (rs1_addr == '0) ? '0 : regs[rs1_addr];
    assign rs2_stored = (rs2_addr == '0) ? '0 : regs[rs2_addr];
    assign dbg_data   = (dbg_addr == '0) ? '0 : regs[dbg_addr];

`ifdef REGFILE_BYPASS_EN
    // -------------------------------------------------------------------------
    // Write-through forwarding
    // -------------------------------------------------------------------------
    // A writeback during reset never lands in the array, so it is not
    // forwarded either. On a forwarded read the port reports busy only when
    // a same-cycle issue re-marks that register.
    logic fwd1;
    logic fwd2;

    assign fwd1 = wr_hit && !reset && (wr_addr == rs1_addr);
    assign fwd2 = wr_hit && !reset && (wr_addr == rs2_addr);

    assign rs1_data = fwd1 ? wr_data : rs1_stored;
    assign rs2_data = fwd2 ? wr_data : rs2_stored;
    assign rs1_busy = fwd1 ? (issue_hit && (issue_addr == rs1_addr))
                           : busy_q[rs1_addr];
    assign rs2_busy = fwd2 ? (issue_hit && (issue_addr == rs2_addr))
                           : busy_q[rs2_addr];
`else
    // The read ports show registered state only. A same-cycle write becomes
    // visible one cycle later.
    assign rs1_data = rs1_stored;
    assign rs2_data = rs2_stored;
    assign rs1_busy = busy_q[rs1_addr];
    assign rs2_busy = busy_q[rs2_addr];
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// -----------------------------------------------------------------------------
// tb_regfile_sb
//
// Self-checking bench for regfile_sb with default parameters.
// Structure:
//   - Clock/reset block.
//   - Driver tasks that set inputs just after a rising edge.
//   - A reference model (register array, busy bits, popcount). The model is
//     updated from the driven inputs at every edge.
//   - A scoreboard. Expected outputs are pushed to exp_q when stimulus is
//     driven, then popped and compared at the falling edge.
//   - Directed scenarios, then a random phase.
//   - A final report.
// The bench follows REGFILE_BYPASS_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_regfile_sb;

    localparam int XLEN    = 32;
    localparam int NREG    = 32;
    localparam int AW      = 5;
    localparam int SP_IDX  = 2;
    localparam int SP_INIT = 31;

    // -------------------------------------------------------------------------
    // Clock / reset and DUT signals
    // -------------------------------------------------------------------------
    logic            clk = 1'b0;
    logic            reset;
    logic [AW-1:0]   rs1_addr, rs2_addr, wr_addr, issue_addr, dbg_addr;
    logic [XLEN-1:0] rs1_data, rs2_data, wr_data, dbg_data;
    logic            rs1_busy, rs2_busy, wr_en, issue_en;
    logic [AW:0]     pend_cnt;

    always #5 clk = ~clk;

    regfile_sb dut (
        .clk        (clk),
        .reset      (reset),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .rs1_busy   (rs1_busy),
        .rs2_busy   (rs2_busy),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .pend_cnt   (pend_cnt),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    // -------------------------------------------------------------------------
    // Reference model and scoreboard
    // -------------------------------------------------------------------------
    logic [XLEN-1:0] m_regs [NREG];
    logic            m_busy [NREG];
    int              m_cnt;
    logic [XLEN-1:0] exp_q[$];
    int              checks = 0;
    int              errors = 0;

    task automatic check_val(input string tag, input logic [XLEN-1:0] obs,
                             input logic [XLEN-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a);
        if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (!reset && wr_en && wr_addr == a) return wr_data;
`endif
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (!reset && wr_en && wr_addr == a) return issue_en && issue_addr == a;
`endif
        return m_busy[a];
    endfunction

    // Push the expected outputs for the inputs currently being driven, wait
    // until the falling edge, then pop and compare.
    task automatic sample();
        exp_q.push_back(exp_rd(rs1_addr));
        exp_q.push_back(exp_rd(rs2_addr));
        exp_q.push_back(XLEN'(exp_busy(rs1_addr)));
        exp_q.push_back(XLEN'(exp_busy(rs2_addr)));
        exp_q.push_back(XLEN'(m_cnt));
        exp_q.push_back((dbg_addr == 0) ? '0 : m_regs[dbg_addr]);
        @(negedge clk);
        check_val("rs1_data", rs1_data, exp_q.pop_front());
        check_val("rs2_data", rs2_data, exp_q.pop_front());
        check_val("rs1_busy", XLEN'(rs1_busy), exp_q.pop_front());
        check_val("rs2_busy", XLEN'(rs2_busy), exp_q.pop_front());
        check_val("pend_cnt", XLEN'(pend_cnt), exp_q.pop_front());
        check_val("dbg_data", dbg_data, exp_q.pop_front());
    endtask

    // Apply the current inputs to the model, then step to just after the edge.
    task automatic advance();
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                m_regs[i] = (i == SP_IDX) ? XLEN'(SP_INIT) : '0;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (wr_en && wr_addr != 0) begin
                m_regs[wr_addr] = wr_data;
                m_busy[wr_addr] = 1'b0;
            end
            if (issue_en && issue_addr != 0) m_busy[issue_addr] = 1'b1;
        end
        m_cnt = 0;
        for (int i = 0; i < NREG; i++) m_cnt += int'(m_busy[i]);
        @(posedge clk);
        #1;
    endtask

    // -------------------------------------------------------------------------
    // Driver tasks
    // -------------------------------------------------------------------------
    task automatic drive_idle();
        reset = 1'b0; wr_en = 1'b0; issue_en = 1'b0;
        wr_addr = '0; wr_data = '0; issue_addr = '0;
    endtask

    task automatic drive_write(input int a, input logic [XLEN-1:0] d);
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
    endtask

    task automatic drive_issue(input int a);
        issue_en = 1'b1; issue_addr = AW'(a);
    endtask

    task automatic drive_reads(input int a1, input int a2, input int ad);
        rs1_addr = AW'(a1); rs2_addr = AW'(a2); dbg_addr = AW'(ad);
    endtask

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        m_cnt = 0;
        drive_idle();
        drive_reads(0, 0, 0);
        reset = 1'b1;
        advance();
        advance();

        // Reset release
        drive_idle();
        drive_reads(2, 5, 2);
        sample();
        check_val("rst_sp", rs1_data, 32'd31);
        check_val("rst_r5", rs2_data, 32'd0);
        check_val("rst_cnt", XLEN'(pend_cnt), 32'd0);
        check_val("rst_busy", XLEN'({rs1_busy, rs2_busy}), 32'd0);
        advance();

        // x0 protection
        drive_write(0, 32'hDEADBEEF);
        drive_issue(0);
        sample(); advance();
        drive_idle(); drive_reads(0, 0, 0);
        sample();
        check_val("x0_data", rs1_data, 32'd0);
        check_val("x0_busy", XLEN'(rs1_busy), 32'd0);
        check_val("x0_cnt", XLEN'(pend_cnt), 32'd0);
        advance();

        // Scoreboard lifecycle
        drive_issue(7); sample(); advance();
        drive_idle(); drive_issue(9); sample(); advance();
        drive_idle(); drive_reads(7, 9, 7);
        sample();
        check_val("life_cnt2", XLEN'(pend_cnt), 32'd2);
        check_val("life_busy7", XLEN'(rs1_busy), 32'd1);
        advance();
        drive_write(7, 32'h1234); sample(); advance();
        drive_idle();
        sample();
        check_val("life_data7", rs1_data, 32'h1234);
        check_val("life_clr7", XLEN'(rs1_busy), 32'd0);
        check_val("life_cnt1", XLEN'(pend_cnt), 32'd1);
        advance();

        // Same-register collision on busy register 9
        drive_issue(9); drive_write(9, 32'hAA); sample(); advance();
        drive_idle(); drive_reads(9, 0, 9);
        sample();
        check_val("coll_data", rs1_data, 32'hAA);
        check_val("coll_busy", XLEN'(rs1_busy), 32'd1);
        check_val("coll_cnt", XLEN'(pend_cnt), 32'd1);
        advance();

        // Same-cycle write versus read
        drive_write(12, 32'h55); drive_reads(0, 12, 12);
        sample();
`ifdef REGFILE_BYPASS_EN
        check_val("byp_same", rs2_data, 32'h55);
`else
        check_val("byp_same", rs2_data, 32'h0);
`endif
        check_val("byp_dbg", dbg_data, 32'h0);
        advance();
        drive_idle();
        sample();
        check_val("byp_next", rs2_data, 32'h55);
        advance();

        // Reset in the middle of operation
        drive_write(2, 32'h100); sample(); advance();
        drive_idle(); drive_issue(3); sample(); advance();
        drive_idle(); drive_issue(4); sample(); advance();
        drive_idle();
        sample();
        check_val("mid_cnt3", XLEN'(pend_cnt), 32'd3);
        advance();
        reset = 1'b1; drive_write(4, 32'h77); drive_issue(5);
        sample(); advance();
        drive_idle(); drive_reads(4, 2, 3);
        sample();
        check_val("mid_r4", rs1_data, 32'd0);
        check_val("mid_sp", rs2_data, 32'd31);
        check_val("mid_cnt0", XLEN'(pend_cnt), 32'd0);
        advance();

        // Random phase: dense issue/writeback traffic with occasional resets
        for (int n = 0; n < 400; n++) begin
            reset      = ($urandom_range(0, 59) == 0);
            wr_en      = ($urandom_range(0, 2) != 0);
            wr_addr    = AW'($urandom_range(0, NREG - 1));
            wr_data    = $urandom;
            issue_en   = ($urandom_range(0, 1) != 0);
            issue_addr = AW'($urandom_range(0, NREG - 1));
            if ($urandom_range(0, 3) == 0) issue_addr = wr_addr;
            rs1_addr   = AW'($urandom_range(0, NREG - 1));
            rs2_addr   = ($urandom_range(0, 2) == 0) ? wr_addr
                                                     : AW'($urandom_range(0, NREG - 1));
            dbg_addr   = AW'($urandom_range(0, NREG - 1));
            sample();
            advance();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor of the processor's integer register file: XLEN-wide, NREG-deep, two combinational read ports and one write port.
- Register 0 is hardwired to zero; the stack-pointer register has a configurable reset value.
- Adds a per-register pending-write scoreboard so the decode stage can detect RAW hazards against multi-cycle ops such as loads.
- Adds a debug read port for board display taps.
- Sits between decode (read/issue) and writeback (write/clear).

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of architectural registers; power of two, minimum 2.
- AW, $clog2(NREG), address width (derived; do not override).
- SP_IDX, 2, index of the stack-pointer register.
- SP_INIT, 31, reset value of register SP_IDX (maximum stack address).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- rs1_addr  in  AW  read port 1 address.
- rs2_addr  in  AW  read port 2 address.
- rs1_data  out  XLEN  read port 1 data (combinational).
- rs2_data  out  XLEN  read port 2 data (combinational).
- rs1_busy  out  1  scoreboard bit for rs1_addr (combinational).
- rs2_busy  out  1  scoreboard bit for rs2_addr (combinational).
- wr_en  in  1  writeback enable.
- wr_addr  in  AW  writeback destination.
- wr_data  in  XLEN  writeback data.
- issue_en  in  1  mark a register as having a write in flight.
- issue_addr  in  AW  register to mark busy.
- pend_cnt  out  AW+1  number of registers currently marked busy.
- dbg_addr  in  AW  debug read address.
- dbg_data  out  XLEN  debug read data (combinational, never bypassed).

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high. While reset is high at a rising edge:
  - every register loads 0, except register SP_IDX, which loads SP_INIT;
  - all busy bits clear and pend_cnt becomes 0;
  - reset dominates wr_en and issue_en in the same cycle.
- Reset values of outputs (combinational, with addresses at 0): rs1_data, rs2_data and dbg_data = 0; rs1_busy and rs2_busy = 0; pend_cnt = 0.
- Register 0:
  - Reads always return 0.
  - Writes to address 0 are discarded.
  - issue_en with issue_addr = 0 is ignored; busy[0] is constant 0.
- Reads: zero latency, combinational on the address. A write is visible on the read ports from the cycle after its wr_en edge (bypass behaviour is covered under Optional Feature).
- Write: when wr_en=1 and wr_addr!=0, regs[wr_addr] <= wr_data at the rising edge. Any writeback to register r also clears busy[r].
- Issue: when issue_en=1 and issue_addr!=0, busy[issue_addr] <= 1 at the rising edge.
- Simultaneous issue and writeback to the same register: the register takes wr_data, and busy stays 1, because the newer in-flight write wins.
- Simultaneous issue and writeback to different registers: both take effect.
- Issue to a register that is already busy: no change; the bit stays 1 and pend_cnt is unchanged.
- Write to a non-busy register (ALU result with no prior issue): data is written, busy stays 0, pend_cnt is unchanged.
- pend_cnt:
  - Registered; equals the popcount of busy after each edge.
  - Updated incrementally: +1 on a new set, -1 on a clear, 0 net when set and clear coincide.
  - Never exceeds NREG-1.
- The busy bits and the two read ports are independent; the block never stalls. Hazard and stall decisions belong to the control unit.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through forwarding. If wr_en=1 and wr_addr==rsN_addr!=0 in the same cycle:
  - rsN_data = wr_data;
  - rsN_busy = 0, unless issue_en=1 with issue_addr==rsN_addr in that same cycle.
  - dbg_data is not bypassed.
- Not defined: read ports show only stored state. A same-cycle write appears on the following cycle; busy reflects the registered bit only.

Test Plan:
- Reset release: reset=1 for 2 cycles, then rs1_addr=2 and rs2_addr=5 -> rs1_data=31, rs2_data=0, pend_cnt=0, both busy=0.
- x0 protection: wr_en=1, wr_addr=0, wr_data=0xDEADBEEF; issue_en=1, issue_addr=0; next cycle rs1_addr=0 -> rs1_data=0, rs1_busy=0, pend_cnt=0.
- Scoreboard lifecycle:
  - issue to 7, then issue to 9 -> pend_cnt=2, rs1_busy(7)=1;
  - write 0x1234 to 7 -> next cycle rs1_data=0x1234, rs1_busy=0, pend_cnt=1.
- Same-register collision: busy[9]=1, then in one cycle issue_en to 9 plus wr_en to 9 with 0xAA -> regs[9]=0xAA, busy[9]=1, pend_cnt=1.
- Bypass:
  - with REGFILE_BYPASS_EN: wr_en to 12 with 0x55 and rs2_addr=12 in the same cycle -> rs2_data=0x55 that cycle;
  - without the macro: old value that cycle, 0x55 the next.
- Reset mid-operation: with busy set on 3 registers and regs[2]=0x100, assert reset together with wr_en to 4 -> regs[4]=0, regs[2]=31, pend_cnt=0.
